dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters: port 0 is the CPU data path and port 1 is the debug/program loader.
- Round-robin arbitration with optional locked bursts.
- Sits between system_cpu_master's data-memory interface and the data memory instance.
- Memory is synchronous: read data is available one cycle after the command.

Parameters:
- ADDR_W, 8, data-memory word-address width.
- DATA_W, 16, data word width.
- MAX_BURST, 4, maximum consecutive grants a locked requester may hold (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  request valid, per port.
- we0 / we1  in  1  1 = write, 0 = read.
- lock0 / lock1  in  1  request to keep the grant for back-to-back beats.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  command accepted this cycle (combinational).
- rvalid0 / rvalid1  out  1  read data valid (registered).
- rdata0 / rdata1  out  DATA_W  read data, routed from mem_rdata.
- mem_en  out  1  memory command strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read command.

Behaviour:
- Reset (rst=0, asynchronous):
  - rvalid0 = rvalid1 = 0.
  - Round-robin pointer `last` = 1, so port 0 has priority first.
  - Lock state cleared; burst counter = 0.
  - Combinational outputs follow from these registered values: gnt = 0, mem_en = 0.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - A command transfers in the cycle where req & gnt = 1.
  - At most one of gnt0/gnt1 is high in any cycle.
  - mem_en = gnt0 | gnt1.
  - mem_we, mem_addr and mem_wdata are muxed from the granted port; they are 0 when idle.
- Arbitration, evaluated each cycle:
  - If a lock is active and its owner has req=1, the owner is granted.
  - Otherwise, if only one port requests, that port is granted.
  - Otherwise, if both request, the port != `last` is granted.
  - `last` updates to the granted port on every grant.
- Lock state machine:
  - States: UNLOCKED, LOCKED(owner).
  - UNLOCKED → LOCKED: on a grant with lock=1; burst counter := 1.
  - While LOCKED, each further grant increments the counter.
  - LOCKED → UNLOCKED: when the owner drops lock or req, or when the counter reaches MAX_BURST on a grant.
  - The beat that reaches MAX_BURST is granted; the lock is released after it.
  - The other port is then granted first if it is requesting (fairness).
  - While LOCKED, the non-owner is never granted, even if the owner's req is low for a cycle; lock release is evaluated in that same cycle, so no stall exceeds one cycle.
- Read return:
  - rvalidN is registered: it is 1 for exactly one cycle, the cycle after a granted read on port N.
  - rdataN = mem_rdata, meaningful only when rvalidN=1.
  - Writes produce no rvalid.
  - Back-to-back reads give one result per cycle. Latency is 1 cycle from grant to rvalid.
- Reset mid-operation: a pending rvalid is dropped; no data is returned after reset release.
- Widths: all data paths are DATA_W; no arithmetic on data. The burst counter is ceil(log2(MAX_BURST+1)) bits and saturates at release.

Test Plan:
1. Reset, then req0 read at addr 0x10, with memory preloaded mem[0x10]=0xBEEF:
   - gnt0=1 in the request cycle; mem_addr=0x10, mem_we=0.
   - Next cycle: rvalid0=1, rdata0=0xBEEF; rvalid1 stays 0.
2. req0 and req1 asserted together for 4 cycles, both writes (port 0 data 0x1111, port 1 data 0x2222):
   - Grant order 0,1,0,1; exactly one gnt per cycle.
   - Memory sees alternating writes.
3. Lock burst, MAX_BURST=4: port 1 holds lock1=1 and req1=1 for 6 cycles while req0 stays high:
   - gnt1 for 4 cycles, then gnt0, then gnt1.
4. Lock released early: port 0 drops lock0 after 2 beats while req1 is pending:
   - Cycle 3 grants port 1.
5. Asynchronous reset asserted mid-clock, one cycle after a granted read on port 1:
   - rvalid1 goes 0 immediately and stays 0 after release.
   - Next simultaneous request grants port 0 first.
6. Write-then-read on port 0: write 0x1234 to 0x05, then read 0x05 the next cycle:
   - rvalid0 with rdata0=0x1234, two cycles after the write grant.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports and the data-memory command/return bus
//   shared by dmem_arbiter.
//   Requester N (N = 0 CPU data path, N = 1 debug/program loader):
//     reqN, weN, lockN, addrN, wdataN  -> towards the arbiter
//     gntN, rvalidN, rdataN            <- from the arbiter
//   Memory side:
//     mem_en, mem_we, mem_addr, mem_wdata -> towards the memory
//     mem_rdata                           <- from the memory (1-cycle latency)
//   Modports: slave (arbiter), master (requesters), memory (memory instance).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic              lock0;
    logic              lock1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
    );

    modport memory (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one synchronous single-port data memory between the CPU data path
//   (port 0) and the debug/program loader (port 1). Round-robin arbitration
//   with optional locked bursts of up to MAX_BURST consecutive beats.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-low reset
//     bus  - dmem_arbiter_if.slave: requester handshakes (req/we/lock/addr/
//            wdata in, gnt/rvalid/rdata out) and memory command bus
//   gntN and the memory command are combinational; rvalidN is registered and
//   rdataN is mem_rdata routed through.
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_e;

    lock_state_e      state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             rvalid0_q, rvalid1_q;

    logic             owner_req;
    logic             owner_lock;
    logic             lock_hold;
    logic             gnt0;
    logic             gnt1;
    logic             gnt_any;
    logic             gnt_lock;
    logic [CNT_W-1:0] cnt_inc;

    // Grant selection. A held lock only counts while the owner keeps lock
    // asserted; if the owner's req drops with lock still high, nobody is
    // granted for that cycle and the lock is released below.
    always_comb begin
        owner_req  = owner_q ? bus.req1  : bus.req0;
        owner_lock = owner_q ? bus.lock1 : bus.lock0;
        lock_hold  = (state_q == LOCKED) && owner_lock;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        if (lock_hold) begin
            gnt0 = owner_req && !owner_q;
            gnt1 = owner_req &&  owner_q;
        end else if (bus.req0 && bus.req1) begin
            // tie goes to the port that was not granted last
            gnt0 = last_q;
            gnt1 = !last_q;
        end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
        end
    end

    assign gnt_any  = gnt0 | gnt1;
    assign gnt_lock = (gnt0 & bus.lock0) | (gnt1 & bus.lock1);
    assign cnt_inc  = cnt_q + 1'b1;

    // Lock / round-robin next state. Releasing on the MAX_BURST beat leaves
    // last_q pointing at the owner, so the other port wins the next tie.
    always_comb begin
        state_d = UNLOCKED;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        if (gnt_any) begin
            last_d = gnt1;
        end
        if (lock_hold) begin
            if (owner_req) begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == CNT_MAX) ? UNLOCKED : LOCKED;
            end
        end else if (gnt_any && gnt_lock && (MAX_BURST > 1)) begin
            state_d = LOCKED;
            owner_d = gnt1;
            cnt_d   = CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= UNLOCKED;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= gnt0 & ~bus.we0;
            rvalid1_q <= gnt1 & ~bus.we1;
        end
    end

    assign bus.gnt0      = gnt0;
    assign bus.gnt1      = gnt1;
    assign bus.mem_en    = gnt_any;
    assign bus.mem_we    = (gnt0 & bus.we0) | (gnt1 & bus.we1);
    assign bus.mem_addr  = ({ADDR_W{gnt0}} & bus.addr0)  | ({ADDR_W{gnt1}} & bus.addr1);
    assign bus.mem_wdata = ({DATA_W{gnt0}} & bus.wdata0) | ({DATA_W{gnt1}} & bus.wdata1);
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata0    = bus.mem_rdata;
    assign bus.rdata1    = bus.mem_rdata;

endmodule
